ssd1306_fb_writer: RTL

- Upstream stage of the SSD1306 frame streamer.
- Renders pixel commands into the 1024-byte page-organised framebuffer RAM via its write port; the streamer reads the same RAM on the other port.
- Supports per-pixel clear/set/toggle using read-modify-write, and whole-buffer fill with a byte pattern.
- Single clock domain, shared with the streamer.

---
 rtl/ssd1306_pkg.sv | 22 ++
 rtl/ssd1306_fb_writer_if.sv | 29 ++
 rtl/fb_pixel_map.sv | 35 +++
 rtl/ssd1306_fb_writer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 framebuffer path: op codes, writer states and
// framebuffer geometry constants.
package ssd1306_pkg;

    localparam int unsigned FB_BYTES = 1024;
    localparam int unsigned PAGE_H   = 8;

    typedef enum logic [1:0] {
        OP_CLEAR_PX  = 2'b00,
        OP_SET_PX    = 2'b01,
        OP_TOGGLE_PX = 2'b10,
        OP_FILL      = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_READ   = 2'b01,
        S_MODIFY = 2'b10,
        S_FILL   = 2'b11
    } state_e;

endpackage

// File: rtl/ssd1306_fb_writer_if.sv
// Command handshake plus framebuffer RAM port of the framebuffer writer.
// Signal names are from the writer's point of view (slave modport).
interface ssd1306_fb_writer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              i_Valid;
    logic              o_Ready;
    logic [1:0]        i_Op;
    logic [6:0]        i_X;
    logic [5:0]        i_Y;
    logic [7:0]        i_Pattern;
    logic [ADDR_W-1:0] o_Rd_Addr;
    logic [7:0]        i_Rd_Data;
    logic              o_Wr_En;
    logic [ADDR_W-1:0] o_Wr_Addr;
    logic [7:0]        o_Wr_Data;
    logic              o_Done;
    logic              o_Err;

    modport slave (
        input  i_Valid, i_Op, i_X, i_Y, i_Pattern, i_Rd_Data,
        output o_Ready, o_Rd_Addr, o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Done, o_Err
    );

    modport master (
        output i_Valid, i_Op, i_X, i_Y, i_Pattern, i_Rd_Data,
        input  o_Ready, o_Rd_Addr, o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Done, o_Err
    );
endinterface

// File: rtl/fb_pixel_map.sv
// Pixel to page-organised framebuffer mapping: byte address, bit index, modified byte
// and range check. Purely combinational so drawing blocks can share it.
module fb_pixel_map
    import ssd1306_pkg::*;
#(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned HEIGHT = 64,
    parameter int unsigned ADDR_W = 10
) (
    input  logic [6:0]        i_X,
    input  logic [5:0]        i_Y,
    input  op_e               i_Op,
    input  logic [7:0]        i_Old,
    output logic [ADDR_W-1:0] o_Addr,
    output logic [2:0]        o_Bit,
    output logic [7:0]        o_New,
    output logic              o_Range_Err
);
    logic [7:0] w_Mask;

    assign o_Bit       = i_Y[2:0];
    assign w_Mask      = 8'b1 << o_Bit;
    assign o_Addr      = ADDR_W'((32'(i_Y) / PAGE_H) * WIDTH + 32'(i_X));
    assign o_Range_Err = (32'(i_X) >= WIDTH) || (32'(i_Y) >= HEIGHT);

    always_comb begin
        o_New = i_Old;
        case (i_Op)
            OP_CLEAR_PX:  o_New = i_Old & ~w_Mask;
            OP_SET_PX:    o_New = i_Old | w_Mask;
            OP_TOGGLE_PX: o_New = i_Old ^ w_Mask;
            default:      ;
        endcase
    end
endmodule

// File: rtl/ssd1306_fb_writer.sv
// Framebuffer writer: per-pixel read-modify-write and whole-buffer fill into the
// page-organised RAM shared with the SSD1306 streamer.
module ssd1306_fb_writer
    import ssd1306_pkg::*;
#(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned HEIGHT = 64,
    parameter int unsigned ADDR_W = 10
) (
    input logic                 i_Clk,
    input logic                 i_Reset,
    ssd1306_fb_writer_if.slave  bus
);
    state_e            r_State;
    op_e               r_Op;
    logic [6:0]        r_X;
    logic [5:0]        r_Y;
    logic [ADDR_W-1:0] r_Rd_Addr;
    logic [ADDR_W-1:0] r_Wr_Addr;
    logic [7:0]        r_Wr_Data;
    logic              r_Wr_En;
    logic              r_Done;
    logic              r_Err;
    logic [ADDR_W:0]   r_Fill_Cnt;

    logic              w_Idle;
    logic [6:0]        w_X;
    logic [5:0]        w_Y;
    op_e               w_Op;
    logic [ADDR_W-1:0] w_Addr;
    logic [2:0]        w_Bit;
    logic [7:0]        w_New;
    logic              w_Range_Err;

    // In IDLE the map sees the live command so the read address is ready at accept.
    assign w_Idle = (r_State == S_IDLE);
    assign w_X    = w_Idle ? bus.i_X : r_X;
    assign w_Y    = w_Idle ? bus.i_Y : r_Y;
    assign w_Op   = w_Idle ? op_e'(bus.i_Op) : r_Op;

    fb_pixel_map #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_map (
        .i_X         (w_X),
        .i_Y         (w_Y),
        .i_Op        (w_Op),
        .i_Old       (bus.i_Rd_Data),
        .o_Addr      (w_Addr),
        .o_Bit       (w_Bit),
        .o_New       (w_New),
        .o_Range_Err (w_Range_Err)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State    <= S_IDLE;
            r_Op       <= OP_CLEAR_PX;
            r_X        <= '0;
            r_Y        <= '0;
            r_Rd_Addr  <= '0;
            r_Wr_Addr  <= '0;
            r_Wr_Data  <= '0;
            r_Wr_En    <= 1'b0;
            r_Done     <= 1'b0;
            r_Err      <= 1'b0;
            r_Fill_Cnt <= '0;
        end else begin
            r_Done <= 1'b0;
            r_Err  <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    if (bus.i_Valid) begin
                        r_Op <= w_Op;
                        r_X  <= bus.i_X;
                        r_Y  <= bus.i_Y;
                        if (w_Op == OP_FILL) begin
                            r_Wr_Addr  <= '0;
                            r_Wr_Data  <= bus.i_Pattern;
                            r_Wr_En    <= 1'b1;
                            r_Fill_Cnt <= (ADDR_W + 1)'(1);
                            r_State    <= S_FILL;
                        end else if (w_Range_Err) begin
                            r_Done <= 1'b1;
                            r_Err  <= 1'b1;
                        end else begin
                            r_Rd_Addr <= w_Addr;
                            r_Wr_Addr <= w_Addr;
                            r_State   <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_Wr_En <= 1'b1;
                    r_State <= S_MODIFY;
                end
                S_MODIFY: begin
                    r_Wr_En <= 1'b0;
                    r_Done  <= 1'b1;
                    r_State <= S_IDLE;
                end
                S_FILL: begin
                    // Counter holds the next address; its MSB marks the last byte in flight.
                    if (r_Fill_Cnt[ADDR_W]) begin
                        r_Wr_En <= 1'b0;
                        r_Done  <= 1'b1;
                        r_State <= S_IDLE;
                    end else begin
                        r_Wr_Addr  <= r_Fill_Cnt[ADDR_W-1:0];
                        r_Fill_Cnt <= r_Fill_Cnt + 1'b1;
                    end
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

    // Read data only arrives in MODIFY, so the pixel write data bypasses the register.
    assign bus.o_Wr_Data = (r_State == S_MODIFY) ? w_New : r_Wr_Data;
    assign bus.o_Ready   = w_Idle;
    assign bus.o_Rd_Addr = r_Rd_Addr;
    assign bus.o_Wr_En   = r_Wr_En;
    assign bus.o_Wr_Addr = r_Wr_Addr;
    assign bus.o_Done    = r_Done;
    assign bus.o_Err     = r_Err;

    a_single_bit_changed : assert property (@(posedge i_Clk) disable iff (i_Reset)
        (r_State == S_MODIFY) |-> (((w_New ^ bus.i_Rd_Data) & ~(8'b1 << w_Bit)) == 8'h00));
endmodule
